scp_fetch_unit: RTL and testbench
=================================

# scp_fetch_unit

Instruction fetch stage directly upstream of the single-cycle controller and datapath. It owns the program counter, requests instructions from instruction memory over a valid/ready handshake, and presents one instruction at a time (`instr_o`, `pc_o`, `pc_plus4_o`) to the decode/execute logic. It then waits for a commit pulse before advancing the PC. On commit, the next PC is either PC+4 or the redirect target from the ALU, selected by `PC_SEL`.

## Interface
- `X_LEN`, 32: address and instruction width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `imem_req_o`  out  1  fetch request valid.
- `imem_addr_o`  out  X_LEN  fetch byte address; always equals `pc_o` while `imem_req_o`=1.
- `imem_ready_i`  in  1  memory accepts the request this cycle.
- `imem_rvalid_i`  in  1  response valid.
- `imem_rdata_i`  in  X_LEN  response instruction word.
- `imem_err_i`  in  1  response error; qualified by `imem_rvalid_i`.
- `commit_i`  in  1  one-cycle pulse: the current instruction has executed; advance the PC.
- `pc_sel_i`  in  1  redirect select (controller `PC_SEL`); sampled only with `commit_i`.
- `target_i`  in  X_LEN  redirect target (ALU result); sampled only with `commit_i`.
- `instr_valid_o`  out  1  `instr_o`/`pc_o` hold a valid fetched instruction.
- `instr_o`  out  X_LEN  fetched instruction; 32'h0000_0013 (NOP) when not valid.
- `pc_o`  out  X_LEN  PC of the current or in-flight fetch.
- `pc_plus4_o`  out  X_LEN  `pc_o` + 4, modulo 2^X_LEN.
- `fault_o`  out  1  sticky fault flag.
- `fault_cause_o`  out  2  00 none, 01 imem error, 10 misaligned target.

## Operation
- FSM states: FETCH, WAIT, HOLD, FAULT.
- FETCH: drive `imem_req_o`=1 and `imem_addr_o`=`pc_o`. When `imem_ready_i`=1, go to WAIT. Otherwise stay in FETCH, keeping the address stable.
- WAIT: `imem_req_o`=0. Only one request is outstanding at a time.
  - On `imem_rvalid_i`=1 with `imem_err_i`=0: latch `imem_rdata_i` into `instr_o` and go to HOLD.
  - On `imem_rvalid_i`=1 with `imem_err_i`=1: go to FAULT with cause 01.
- HOLD: `instr_valid_o`=1. On `commit_i`=1, compute the next PC, then return to FETCH.
  - `pc_sel_i`=0: next PC = `pc_o`+4, wrapping modulo 2^X_LEN (32'hFFFF_FFFC → 0).
  - `pc_sel_i`=1: next PC = `target_i` with bit 0 forced to 0 (JALR rule).
  - If the resulting next PC has bit 1 set, do not load it. Go to FAULT with cause 10.
- FAULT: `imem_req_o`=0 and `instr_valid_o`=0. `pc_o` keeps the PC of the faulting instruction. All inputs are ignored. Only `rst_i` exits this state.
- `commit_i` outside HOLD is ignored.
- `imem_rvalid_i` outside WAIT is ignored; a protocol-violating response is dropped.
- When `instr_valid_o`=0, `instr_o` reads as NOP, so downstream decode produces no register or memory writes.

## Timing
- Reset, when `rst_i`=1 at an edge:
  - Next cycle: state=FETCH, `pc_o`=RESET_PC, `imem_req_o`=1, `instr_valid_o`=0, `instr_o`=NOP, `fault_o`=0, `fault_cause_o`=00.
  - Reset wins over every simultaneous event.
  - Reset mid-WAIT abandons the request. Instruction memory shares `rst_i`, so no stale response arrives.
- Best-case latency:
  - Request accepted at edge N.
  - `imem_rvalid_i` at edge N+1.
  - `instr_valid_o`=1 from cycle N+2.
- The response must arrive no earlier than the cycle after acceptance.
- `commit_i` at edge M in HOLD: `instr_valid_o`=0 and the new `pc_o` are visible in cycle M+1, with `imem_req_o`=1 in the same cycle.
- Throughput is at most one instruction per 3 cycles with zero-wait memory.
- `pc_plus4_o` is combinational from `pc_o`. All other outputs are registered or decoded directly from state.

## Test plan
- Reset: hold `rst_i` for 2 cycles with RESET_PC=0x100 → `pc_o`=0x100, `imem_req_o`=1, `instr_valid_o`=0, `instr_o`=0x00000013, `fault_o`=0.
- Sequential fetch: zero-wait memory returns 0x00500093 at 0x0, then commit with `pc_sel_i`=0 → `instr_valid_o` rises 2 cycles after acceptance; next `imem_addr_o`=0x4; `pc_plus4_o`=0x8.
- Backpressure: hold `imem_ready_i`=0 for 5 cycles, then response delayed 3 cycles → `imem_addr_o` is stable throughout, exactly one acceptance, one instruction latched.
- Redirect: commit with `pc_sel_i`=1, `target_i`=0x0000_0041 → next fetch address 0x40. Separately, `target_i`=0x0000_0046 → `fault_o`=1, `fault_cause_o`=10, `pc_o` unchanged, no further requests.
- Error and wrap: `imem_err_i`=1 on response → FAULT with cause 01, stays there until reset. Separately, PC=0xFFFFFFFC with sequential commit → next `pc_o`=0x0.
- Reset in WAIT and stray inputs: assert `rst_i` while in WAIT → refetch from RESET_PC. `commit_i` pulsed in FETCH/WAIT → PC unchanged.

Source files
------------

// File: rtl/scp_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one instruction at a time over a
// valid/ready memory port and holds it until the execute stage commits it.
module scp_fetch_unit #(
   parameter int               X_LEN    = 32,
   parameter logic [X_LEN-1:0] RESET_PC = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic             imem_req_o,
   output logic [X_LEN-1:0] imem_addr_o,
   input  logic             imem_ready_i,
   input  logic             imem_rvalid_i,
   input  logic [X_LEN-1:0] imem_rdata_i,
   input  logic             imem_err_i,
   input  logic             commit_i,
   input  logic             pc_sel_i,
   input  logic [X_LEN-1:0] target_i,
   output logic             instr_valid_o,
   output logic [X_LEN-1:0] instr_o,
   output logic [X_LEN-1:0] pc_o,
   output logic [X_LEN-1:0] pc_plus4_o,
   output logic             fault_o,
   output logic [1:0]       fault_cause_o
);

   localparam logic [X_LEN-1:0] NOP_INSTR = X_LEN'(32'h0000_0013);
   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_IMEM  = 2'b01;
   localparam logic [1:0] CAUSE_ALIGN = 2'b10;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [X_LEN-1:0] pc_q, pc_d;
   logic [X_LEN-1:0] instr_q, instr_d;
   logic [1:0]       cause_q, cause_d;

   logic [X_LEN-1:0] seq_pc;
   logic [X_LEN-1:0] redirect_pc;
   logic [X_LEN-1:0] next_pc;

   assign seq_pc      = pc_q + X_LEN'(4);
   // JALR semantics: the redirect target always has bit 0 cleared.
   assign redirect_pc = target_i & ~X_LEN'(1);
   assign next_pc     = pc_sel_i ? redirect_pc : seq_pc;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      cause_d = cause_q;
      case (state_q)
         ST_FETCH: begin
            if (imem_ready_i) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid_i) begin
               if (imem_err_i) begin
                  state_d = ST_FAULT;
                  cause_d = CAUSE_IMEM;
               end else begin
                  state_d = ST_HOLD;
                  instr_d = imem_rdata_i;
               end
            end
         end
         ST_HOLD: begin
            if (commit_i) begin
               // Instruction is retired either way; downstream sees NOP from here on.
               instr_d = NOP_INSTR;
               if (next_pc[1]) begin
                  state_d = ST_FAULT;
                  cause_d = CAUSE_ALIGN;
               end else begin
                  state_d = ST_FETCH;
                  pc_d    = next_pc;
               end
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_FAULT;
         end
      endcase
   end

   assign imem_req_o    = (state_q == ST_FETCH);
   assign imem_addr_o   = pc_q;
   assign instr_valid_o = (state_q == ST_HOLD);
   assign instr_o       = instr_q;
   assign pc_o          = pc_q;
   assign pc_plus4_o    = seq_pc;
   assign fault_o       = (state_q == ST_FAULT);
   assign fault_cause_o = cause_q;

endmodule

// File: tb/tb_scp_fetch_unit.sv
// Randomised scoreboard bench for scp_fetch_unit: a driver plays the memory and
// the execute stage while a negedge monitor checks the DUT against queued expectations.
`timescale 1ns/1ps
module tb_scp_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ready = 1'b0, rvalid = 1'b0, err = 1'b0;
   logic        commit = 1'b0, sel = 1'b0;
   logic [31:0] rdata = '0, target = '0;

   logic        imem_req_o, instr_valid_o, fault_o;
   logic [31:0] imem_addr_o, instr_o, pc_o, pc_plus4_o;
   logic [1:0]  fault_cause_o;

   always #5 clk = ~clk;

   scp_fetch_unit #(.X_LEN(32), .RESET_PC(RST_PC)) dut (
      .clk_i(clk), .rst_i(rst),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(ready),
      .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .imem_err_i(err),
      .commit_i(commit), .pc_sel_i(sel), .target_i(target),
      .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o),
      .pc_plus4_o(pc_plus4_o), .fault_o(fault_o), .fault_cause_o(fault_cause_o)
   );

   typedef struct { logic [31:0] pc; logic [31:0] instr; int lat; } instr_t;
   typedef struct { logic [1:0] cause; logic [31:0] pc; } fault_t;

   logic [31:0] exp_addr_q[$];
   instr_t      exp_instr_q[$];
   fault_t      exp_fault_q[$];

   int          n_tests = 0, n_fail = 0;
   int          cyc = 0;
   int          n_accepts = 0;
   bit          mon_en = 1'b0;
   logic [31:0] model_pc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Monitor: pops expectations whenever the DUT presents an event.
   initial begin
      logic        prev_valid, prev_stall, prev_fault, commit_pend;
      logic [31:0] prev_addr, prev_pc;
      int          acc_cyc;
      instr_t      ei;
      fault_t      ef;
      prev_valid = 0; prev_stall = 0; prev_fault = 0; commit_pend = 0;
      prev_addr = '0; prev_pc = '0; acc_cyc = 0;
      forever begin
         @(negedge clk);
         if (!mon_en || rst) begin
            prev_valid = 0; prev_stall = 0; prev_fault = 0; commit_pend = 0;
            continue;
         end
         if (commit_pend) begin
            check("commit_valid_drop", {31'd0, instr_valid_o}, 32'd0);
            check("commit_next_req_or_fault", {31'd0, imem_req_o | fault_o}, 32'd1);
            commit_pend = 0;
         end
         if (!instr_valid_o) check("nop_when_invalid", instr_o, NOP);
         if (prev_stall && imem_req_o) check("addr_stable", imem_addr_o, prev_addr);
         if (imem_req_o && ready) begin
            n_accepts++;
            if (exp_addr_q.size() == 0) fail_now("unexpected_accept");
            else check("fetch_addr", imem_addr_o, exp_addr_q.pop_front());
            check("addr_eq_pc", imem_addr_o, pc_o);
            acc_cyc = cyc;
         end
         if (instr_valid_o && !prev_valid) begin
            if (exp_instr_q.size() == 0) fail_now("unexpected_instr");
            else begin
               ei = exp_instr_q.pop_front();
               check("instr", instr_o, ei.instr);
               check("instr_pc", pc_o, ei.pc);
               check("pc_plus4", pc_plus4_o, ei.pc + 32'd4);
               check("fetch_latency", cyc - acc_cyc, ei.lat);
            end
         end
         if (instr_valid_o && commit) commit_pend = 1;
         if (fault_o && !prev_fault) begin
            if (exp_fault_q.size() == 0) fail_now("unexpected_fault");
            else begin
               ef = exp_fault_q.pop_front();
               check("fault_cause", {30'd0, fault_cause_o}, {30'd0, ef.cause});
               check("fault_pc", pc_o, ef.pc);
            end
         end
         if (prev_fault) begin
            check("fault_sticky", {31'd0, fault_o}, 32'd1);
            check("fault_pc_hold", pc_o, prev_pc);
         end
         if (fault_o) check("fault_quiet", {30'd0, imem_req_o, instr_valid_o}, 32'd0);
         prev_valid = instr_valid_o;
         prev_fault = fault_o;
         prev_stall = imem_req_o && !ready;
         prev_addr  = imem_addr_o;
         prev_pc    = pc_o;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      ready = 0; rvalid = 0; err = 0; commit = 0; sel = 0;
      if (mon_en) begin
         check("sb_addr_drained", exp_addr_q.size() > 1 ? 32'd1 : 32'd0, 32'd0);
         check("sb_instr_drained", exp_instr_q.size(), 32'd0);
         check("sb_fault_drained", exp_fault_q.size(), 32'd0);
      end
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      exp_addr_q.delete();
      exp_instr_q.delete();
      exp_fault_q.delete();
      model_pc = RST_PC;
      exp_addr_q.push_back(RST_PC);
      mon_en = 1;
      check("rst_pc", pc_o, RST_PC);
      check("rst_req", {31'd0, imem_req_o}, 32'd1);
      check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
      check("rst_instr", instr_o, NOP);
      check("rst_fault", {29'd0, fault_o, fault_cause_o}, 32'd0);
   endtask

   // Fault must ignore everything until reset.
   task automatic idle_fault();
      for (int i = 0; i < 4; i++) begin
         ready = 1'($urandom); rvalid = 1'($urandom); commit = 1'($urandom);
         sel = 1'($urandom); rdata = $urandom; target = $urandom;
         step();
      end
      ready = 0; rvalid = 0; commit = 0; sel = 0;
      do_reset();
   endtask

   task automatic wait_req(output bit ok);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (imem_req_o) begin
            ok = 1;
            break;
         end
         step();
      end
      if (!ok) fail_now("req_timeout");
   endtask

   task automatic do_txn(input int stall, input int dly, input bit err_b, input bit sel_b,
                         input logic [31:0] tgt, input logic [31:0] data, input int hold,
                         input bit stray, input bit rst_in_wait);
      bit          ok;
      logic [31:0] nxt;
      instr_t      ei;
      fault_t      ef;
      wait_req(ok);
      if (!ok) begin
         do_reset();
         return;
      end
      for (int i = 0; i < stall; i++) begin
         ready = 0;
         if (stray) begin
            commit = 1; sel = 1; target = $urandom; rvalid = 1; rdata = $urandom;
         end
         step();
         commit = 0; sel = 0; rvalid = 0;
      end
      ready = 1;
      step();
      ready = 0;
      if (rst_in_wait) begin
         do_reset();
         return;
      end
      for (int i = 0; i < dly; i++) begin
         if (stray) begin
            commit = 1; sel = 1; target = $urandom;
         end
         step();
         commit = 0; sel = 0;
      end
      rvalid = 1; err = err_b; rdata = data;
      if (err_b) begin
         ef.cause = 2'b01; ef.pc = model_pc;
         exp_fault_q.push_back(ef);
      end else begin
         ei.pc = model_pc; ei.instr = data; ei.lat = dly + 2;
         exp_instr_q.push_back(ei);
      end
      step();
      rvalid = 0; err = 0;
      if (err_b) begin
         idle_fault();
         return;
      end
      for (int i = 0; i < hold; i++) begin
         if (stray) begin
            rvalid = 1; rdata = $urandom;
         end
         step();
         rvalid = 0;
      end
      commit = 1; sel = sel_b; target = tgt;
      nxt = sel_b ? {tgt[31:1], 1'b0} : model_pc + 32'd4;
      if (nxt[1]) begin
         ef.cause = 2'b10; ef.pc = model_pc;
         exp_fault_q.push_back(ef);
      end else begin
         model_pc = nxt;
         exp_addr_q.push_back(nxt);
      end
      step();
      commit = 0; sel = 0;
      if (nxt[1]) idle_fault();
   endtask

   initial begin
      int          acc_before;
      logic [31:0] tgt;
      do_reset();
      // Directed: redirect to 0, sequential fetch at 0 then 4.
      do_txn(0, 0, 0, 1, 32'h0000_0000, 32'h0050_0093, 0, 0, 0);
      do_txn(0, 0, 0, 0, 32'h0,         32'h0050_0093, 1, 0, 0);
      // Backpressure: 5 stall cycles, 3-cycle response delay, exactly one accept.
      acc_before = n_accepts;
      do_txn(5, 3, 0, 0, 32'h0,         32'h0010_0113, 0, 1, 0);
      check("one_accept", n_accepts - acc_before, 32'd1);
      // Redirect with bit 0 set, then wrap from 0xFFFFFFFC.
      do_txn(0, 1, 0, 1, 32'h0000_0041, 32'h1111_1111, 2, 0, 0);
      do_txn(0, 0, 0, 1, 32'hFFFF_FFFC, 32'h2222_2222, 0, 0, 0);
      do_txn(1, 0, 0, 0, 32'h0,         32'h3333_3333, 0, 0, 0);
      do_txn(0, 0, 0, 0, 32'h0,         32'h4444_4444, 0, 0, 0);
      // Misaligned redirect, memory error, reset mid-WAIT.
      do_txn(0, 0, 0, 1, 32'h0000_0046, 32'h5555_5555, 0, 0, 0);
      do_txn(2, 1, 1, 0, 32'h0,         32'h6666_6666, 0, 0, 0);
      do_txn(0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 1);
      do_txn(0, 0, 0, 0, 32'h0,         32'h7777_7777, 0, 1, 0);
      // Randomised traffic.
      for (int n = 0; n < 150; n++) begin
         tgt = ($urandom & 32'h0000_0FFC) |
               (($urandom_range(0, 7) == 0) ? 32'h2 : ($urandom & 32'h1));
         do_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 24) == 0,
                $urandom_range(0, 2) == 0, tgt, $urandom, $urandom_range(0, 2),
                1'($urandom), $urandom_range(0, 29) == 0);
      end
      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      fail_now("global_timeout");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
